inst_packer: RTL and testbench
==============================

Name: inst_packer

Overview:
- Transmit-side counterpart of the instruction field decoder.
- Accepts decoded instruction fields (fn, three dests, three srcs, each a name plus an index) over a valid/ready handshake.
- Packs the fields into one instruction word and streams the words into a PE instruction memory write port with auto-incrementing addresses.
- Used by the loader that programs each PE's instruction memory before a run.

Parameters:
- fnLen, 3, opcode width
- nameLen, 3, operand namespace width
- indexLen, 8, operand index width
- instLen, fnLen+6*nameLen+6*indexLen (69), packed word width
- addrLen, 8, instruction memory address width
- fifoDepth, 2, output buffer entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a program load
- progLen  in  addrLen  number of instructions to load (0 = 2^addrLen)
- fn  in  fnLen  opcode
- dest0Name/dest1Name/dest2Name  in  nameLen  destination namespaces
- dest0Index/dest1Index/dest2Index  in  indexLen  destination indices
- src0Name/src1Name/src2Name  in  nameLen  source namespaces
- src0Index/src1Index/src2Index  in  indexLen  source indices
- in_v  in  1  field bundle valid
- in_rdy  out  1  packer can accept a bundle
- mem_wr_en  out  1  instruction memory write strobe
- mem_wr_addr  out  addrLen  write address
- mem_wr_data  out  instLen  packed instruction word
- mem_wr_rdy  in  1  memory accepts a write this cycle
- busy  out  1  load in progress
- done  out  1  one-cycle pulse after the final write
- err  out  1  sticky; start received while busy

Behaviour:
- Packing, MSB to LSB, contiguous: fn[68:66], dest0Name[65:63], dest0Index[62:55], dest1Name[54:52], dest1Index[51:44], dest2Name[43:41], dest2Index[40:33], src0Name[32:30], src0Index[29:22], src1Name[21:19], src1Index[18:11], src2Name[10:8], src2Index[7:0].
- Decoding a packed word must reproduce the input fields exactly.
- Reset values: in_rdy=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, err=0. FIFO is empty, and the accept and write counters are 0.
- States:
  - IDLE: in_rdy=0, busy=0. start -> LOAD; latch progLen; clear both counters.
  - LOAD: busy=1. in_rdy=1 when the FIFO is not full and accept count < progLen. An accept happens when in_v&in_rdy; the packed word is pushed into the FIFO the same cycle and the accept count increments. When the final write is accepted -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Write side:
  - mem_wr_en = FIFO not empty (data is registered, from the FIFO head).
  - A write completes when mem_wr_en&mem_wr_rdy; the FIFO pops and mem_wr_addr increments.
  - mem_wr_addr, mem_wr_data and mem_wr_en are held stable while mem_wr_rdy=0.
- Latency: a bundle accepted in cycle N gives mem_wr_en=1 in cycle N+1 (FIFO was empty) with its word.
- Throughput: 1 word/cycle when mem_wr_rdy is held high.
- Simultaneous push and pop on a full FIFO: the push is not allowed (in_rdy is computed from full). Simultaneous push and pop on a non-full FIFO: occupancy is unchanged.
- Address wraps modulo 2^addrLen; progLen=0 loads 2^addrLen words ending with addr=2^addrLen-1.
- Accept count saturates at progLen; in_v after that is ignored (in_rdy=0).
- start while busy: ignored, err set until reset.
- start in the same cycle as the DONE state: ignored without error; done has priority.
- reset mid-load: everything returns to reset values next cycle. Buffered words are discarded and never written.
- in_v with in_rdy=0: no state change; the fields are not captured.

Test Plan:
- Single instruction: start, progLen=1; fn=3'b101, all other fields 0 -> one write, addr 0, data 69'h14_0000_0000_0000_0000; done pulses the cycle after the write completes.
- Field isolation: for each field in turn, drive all ones with the others 0 -> exactly that bit range set (e.g. src2Index=8'hAB gives data 69'hAB; dest0Index=8'hFF gives bits 62:55 set). Decoding the word returns the inputs.
- Backpressure: progLen=4, in_v held high, mem_wr_rdy low for cycles 2-6 -> at most fifoDepth words buffered; in_rdy=0 while full; addresses 0,1,2,3 in order; no word lost or duplicated.
- Wrap: addrLen=8, progLen=0, 256 bundles -> addresses 0..255, done after the write to 255; 257th in_v is not accepted.
- Protocol errors: start during LOAD -> err=1, load continues unaffected. Reset asserted with 1 word buffered -> no further mem_wr_en; all outputs at reset values.

Source files
------------

// File: rtl/inst_packer_if.sv
// Field-bundle handshake and instruction-memory write port of inst_packer.
// The loader drives the master side; the packer uses the slave side.
interface inst_packer_if #(
  parameter int fnLen    = 3,
  parameter int nameLen  = 3,
  parameter int indexLen = 8,
  parameter int addrLen  = 8
);
  localparam int instLen = fnLen + 6*nameLen + 6*indexLen;

  logic [fnLen-1:0]    fn;
  logic [nameLen-1:0]  dest0Name;
  logic [nameLen-1:0]  dest1Name;
  logic [nameLen-1:0]  dest2Name;
  logic [indexLen-1:0] dest0Index;
  logic [indexLen-1:0] dest1Index;
  logic [indexLen-1:0] dest2Index;
  logic [nameLen-1:0]  src0Name;
  logic [nameLen-1:0]  src1Name;
  logic [nameLen-1:0]  src2Name;
  logic [indexLen-1:0] src0Index;
  logic [indexLen-1:0] src1Index;
  logic [indexLen-1:0] src2Index;
  logic                in_v;
  logic                in_rdy;

  logic                mem_wr_en;
  logic [addrLen-1:0]  mem_wr_addr;
  logic [instLen-1:0]  mem_wr_data;
  logic                mem_wr_rdy;

  modport master (
    output fn,
    output dest0Name, dest1Name, dest2Name,
    output dest0Index, dest1Index, dest2Index,
    output src0Name, src1Name, src2Name,
    output src0Index, src1Index, src2Index,
    output in_v,
    input  in_rdy,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_wr_rdy
  );

  modport slave (
    input  fn,
    input  dest0Name, dest1Name, dest2Name,
    input  dest0Index, dest1Index, dest2Index,
    input  src0Name, src1Name, src2Name,
    input  src0Index, src1Index, src2Index,
    input  in_v,
    output in_rdy,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_wr_rdy
  );
endinterface

// File: rtl/inst_packer.sv
// Packs decoded instruction fields into one word and streams the words into a
// PE instruction memory write port at auto-incrementing addresses.
module inst_packer #(
  parameter int fnLen     = 3,
  parameter int nameLen   = 3,
  parameter int indexLen  = 8,
  parameter int addrLen   = 8,
  parameter int fifoDepth = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addrLen-1:0] progLen,
  inst_packer_if.slave       bus,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int instLen = fnLen + 6*nameLen + 6*indexLen;
  localparam int ptrW    = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int occW    = ptrW + 1;
  localparam int cntW    = addrLen + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  function automatic logic [instLen-1:0] pack_fields(
    input logic [fnLen-1:0]    f_fn,
    input logic [nameLen-1:0]  d0n, input logic [indexLen-1:0] d0i,
    input logic [nameLen-1:0]  d1n, input logic [indexLen-1:0] d1i,
    input logic [nameLen-1:0]  d2n, input logic [indexLen-1:0] d2i,
    input logic [nameLen-1:0]  s0n, input logic [indexLen-1:0] s0i,
    input logic [nameLen-1:0]  s1n, input logic [indexLen-1:0] s1i,
    input logic [nameLen-1:0]  s2n, input logic [indexLen-1:0] s2i
  );
    return {f_fn, d0n, d0i, d1n, d1i, d2n, d2i, s0n, s0i, s1n, s1i, s2n, s2i};
  endfunction

  state_t             state, state_nx;
  logic [cntW-1:0]    total_len, acc_cnt, wr_cnt;
  logic [instLen-1:0] fifo_mem [fifoDepth];
  logic [ptrW-1:0]    wr_ptr, rd_ptr;
  logic [occW-1:0]    occ;
  logic               full, in_rdy_c, last_wr, pop;
  logic               vld_p0, vld_p1;
  logic [instLen-1:0] word_p0, word_p1;

  assign full    = (occ == occW'(fifoDepth));
  assign last_wr = (wr_cnt == total_len - cntW'(1));

  // Stage p0: pack the bundle; it enters the buffer on accept
  assign word_p0 = pack_fields(bus.fn,
                               bus.dest0Name, bus.dest0Index,
                               bus.dest1Name, bus.dest1Index,
                               bus.dest2Name, bus.dest2Index,
                               bus.src0Name,  bus.src0Index,
                               bus.src1Name,  bus.src1Index,
                               bus.src2Name,  bus.src2Index);
  assign vld_p0  = bus.in_v && in_rdy_c;

  // Stage p1: buffer head drives the write port, held until the memory takes it
  assign vld_p1  = (occ != '0);
  assign word_p1 = vld_p1 ? fifo_mem[rd_ptr] : '0;
  assign pop     = vld_p1 && bus.mem_wr_rdy;

  assign bus.in_rdy      = in_rdy_c;
  assign bus.mem_wr_en   = vld_p1;
  assign bus.mem_wr_addr = wr_cnt[addrLen-1:0];
  assign bus.mem_wr_data = word_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_rdy_c = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_rdy_c = !full && (acc_cnt < total_len);
        if (pop && last_wr) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // progLen of zero means a full 2^addrLen load, hence the extra count bit
  always_ff @(posedge clk) begin
    if (reset) begin
      total_len <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        total_len <= {progLen == '0, progLen};
        acc_cnt   <= '0;
        wr_cnt    <= '0;
      end else begin
        if (vld_p0) acc_cnt <= acc_cnt + cntW'(1);
        if (pop)    wr_cnt  <= wr_cnt + cntW'(1);
      end
      if (vld_p0) wr_ptr <= wr_ptr + ptrW'(1);
      if (pop)    rd_ptr <= rd_ptr + ptrW'(1);
      case ({vld_p0, pop})
        2'b10:   occ <= occ + occW'(1);
        2'b01:   occ <= occ - occW'(1);
        default: occ <= occ;
      endcase
      if (start && state == LOAD) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) fifo_mem[wr_ptr] <= word_p0;
  end
endmodule

// File: tb/tb_inst_packer.sv
// Randomized bench for inst_packer against a queue-based reference model.
module tb_inst_packer;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset, start, busy, done, err;
  logic [7:0] progLen;

  always #5 clk = ~clk;

  inst_packer_if #(.fnLen(3), .nameLen(3), .indexLen(8), .addrLen(8)) bus();

  inst_packer #(.fnLen(3), .nameLen(3), .indexLen(8), .addrLen(8), .fifoDepth(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .progLen(progLen),
    .bus(bus.slave), .busy(busy), .done(done), .err(err)
  );

  // nm/ix index 0..2 = dest0..2, 3..5 = src0..2
  typedef struct packed {
    logic [2:0]      fn;
    logic [5:0][2:0] nm;
    logic [5:0][7:0] ix;
  } fields_t;

  typedef enum int {M_IDLE, M_LOAD, M_DONE} mstate_t;

  fields_t cur;
  assign bus.fn         = cur.fn;
  assign bus.dest0Name  = cur.nm[0];
  assign bus.dest0Index = cur.ix[0];
  assign bus.dest1Name  = cur.nm[1];
  assign bus.dest1Index = cur.ix[1];
  assign bus.dest2Name  = cur.nm[2];
  assign bus.dest2Index = cur.ix[2];
  assign bus.src0Name   = cur.nm[3];
  assign bus.src0Index  = cur.ix[3];
  assign bus.src1Name   = cur.nm[4];
  assign bus.src1Index  = cur.ix[4];
  assign bus.src2Name   = cur.nm[5];
  assign bus.src2Index  = cur.ix[5];

  mstate_t     m_state;
  int          m_acc, m_wr, m_len;
  bit          m_err;
  fields_t     q[$];
  int          n_vec, n_err, wr_total, last_addr;
  logic [68:0] last_wr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [68:0] ref_word(input fields_t f);
    logic [68:0] w;
    w = 69'(f.fn) << 66;
    for (int k = 0; k < 6; k++) begin
      w |= 69'(f.nm[k]) << (63 - 11*k);
      w |= 69'(f.ix[k]) << (55 - 11*k);
    end
    return w;
  endfunction

  function automatic fields_t decode(input logic [68:0] w);
    fields_t f;
    f.fn    = w[68:66];
    f.nm[0] = w[65:63]; f.ix[0] = w[62:55];
    f.nm[1] = w[54:52]; f.ix[1] = w[51:44];
    f.nm[2] = w[43:41]; f.ix[2] = w[40:33];
    f.nm[3] = w[32:30]; f.ix[3] = w[29:22];
    f.nm[4] = w[21:19]; f.ix[4] = w[18:11];
    f.nm[5] = w[10:8];  f.ix[5] = w[7:0];
    return f;
  endfunction

  function automatic bit m_in_rdy();
    return (m_state == M_LOAD) && ((m_acc - m_wr) < DEPTH) && (m_acc < m_len);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_acc = 0; m_wr = 0; m_len = 0; m_err = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bus.in_v = 1'b0; bus.mem_wr_rdy = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: compare outputs with the model, drive inputs, advance the model.
  task automatic cycle(input bit st, input logic [7:0] pl, input bit v, input bit r);
    bit          acc, wr, rdy_e;
    logic [68:0] exp_data;
    rdy_e    = m_in_rdy();
    exp_data = (q.size() != 0) ? ref_word(q[0]) : 69'h0;
    check("in_rdy",  128'(bus.in_rdy),      128'(rdy_e));
    check("wr_en",   128'(bus.mem_wr_en),   128'(q.size() != 0));
    check("wr_addr", 128'(bus.mem_wr_addr), 128'(m_wr % 256));
    check("wr_data", 128'(bus.mem_wr_data), 128'(exp_data));
    check("busy",    128'(busy),            128'(m_state == M_LOAD));
    check("done",    128'(done),            128'(m_state == M_DONE));
    check("err",     128'(err),             128'(m_err));
    start = st; progLen = pl; bus.in_v = v; bus.mem_wr_rdy = r;
    acc = v && rdy_e;
    wr  = (q.size() != 0) && r;
    if (wr) begin
      last_wr   = bus.mem_wr_data;
      last_addr = int'(bus.mem_wr_addr);
      check("decode", 128'(decode(bus.mem_wr_data)), 128'(q[0]));
      wr_total++;
    end
    @(posedge clk);
    case (m_state)
      M_IDLE: if (st) begin
        m_state = M_LOAD; m_acc = 0; m_wr = 0;
        m_len = (pl == 8'd0) ? 256 : int'(pl);
      end
      M_LOAD: begin
        if (st) m_err = 1'b1;
        if (wr && (m_wr + 1 == m_len)) m_state = M_DONE;
      end
      default: m_state = M_IDLE;
    endcase
    if (acc) begin q.push_back(cur); m_acc++; end
    if (wr) begin void'(q.pop_front()); m_wr++; end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_fields();
    logic [95:0] t;
    t   = {$urandom, $urandom, $urandom};
    cur = t[68:0];
  endtask

  task automatic run_load(input logic [7:0] pl, input int vpct, input int rpct, input bit rnd,
                          input bit bp, input int start_at, input bit start_in_done,
                          output int nwr);
    int c, w0;
    bit st, v, r;
    w0 = wr_total;
    cycle(1'b1, pl, 1'b0, 1'b1);
    c = 1;
    while (m_state != M_IDLE) begin
      if (c > 3000) begin
        check("timeout", 128'(1), 128'(0));
        break;
      end
      v  = ($urandom_range(99) < vpct);
      r  = ($urandom_range(99) < rpct);
      if (bp && c >= 2 && c <= 6) r = 1'b0;
      st = (c == start_at) || (start_in_done && m_state == M_DONE);
      if (rnd) rand_fields();
      cycle(st, pl, v, r);
      c++;
    end
    cycle(1'b0, pl, 1'b1, 1'b1);
    nwr = wr_total - w0;
  endtask

  int fw[13]   = '{3, 3, 8, 3, 8, 3, 8, 3, 8, 3, 8, 3, 8};
  int flsb[13] = '{66, 63, 55, 52, 44, 41, 33, 30, 22, 19, 11, 8, 0};

  initial begin
    int n, pl;
    n_vec = 0; n_err = 0; wr_total = 0; last_addr = 0; last_wr = '0;
    cur = '0; start = 1'b0; progLen = '0; bus.in_v = 1'b0; bus.mem_wr_rdy = 1'b0;
    do_reset();
    do_reset();
    cycle(1'b0, 8'd0, 1'b1, 1'b1);

    cur = '0; cur.fn = 3'b101;
    run_load(8'd1, 100, 100, 1'b0, 1'b0, -1, 1'b0, n);
    check("single_cnt",  128'(n),       128'(1));
    check("single_word", 128'(last_wr), 128'(69'h14_0000_0000_0000_0000));

    for (int k = 0; k < 13; k++) begin
      cur = '0;
      if (k == 0)         cur.fn = '1;
      else if (k % 2 == 1) cur.nm[(k-1)/2] = '1;
      else                cur.ix[k/2-1] = '1;
      run_load(8'd1, 100, 100, 1'b0, 1'b0, -1, 1'b0, n);
      check("field_iso", 128'(last_wr), 128'(((69'(1) << fw[k]) - 69'(1)) << flsb[k]));
    end
    cur = '0; cur.ix[5] = 8'hAB;
    run_load(8'd1, 100, 100, 1'b0, 1'b0, -1, 1'b0, n);
    check("src2_index_ab", 128'(last_wr), 128'(69'hAB));
    cur = '0; cur.ix[0] = 8'hFF;
    run_load(8'd1, 100, 100, 1'b0, 1'b0, -1, 1'b0, n);
    check("dest0_index_ff", 128'(last_wr), 128'(69'h7F80_0000_0000_0000));

    run_load(8'd4, 100, 100, 1'b1, 1'b1, -1, 1'b0, n);
    check("bp_count", 128'(n), 128'(4));
    check("bp_last_addr", 128'(last_addr), 128'(3));

    for (int i = 0; i < 6; i++) begin
      pl = int'($urandom_range(1, 20));
      run_load(8'(pl), 70, 60, 1'b1, 1'b0, -1, 1'b0, n);
      check("rand_count", 128'(n), 128'(pl));
    end

    run_load(8'd3, 100, 100, 1'b1, 1'b0, -1, 1'b1, n);
    check("start_in_done_err", 128'(err), 128'(0));

    run_load(8'd0, 100, 80, 1'b1, 1'b0, -1, 1'b0, n);
    check("wrap_count", 128'(n), 128'(256));
    check("wrap_last_addr", 128'(last_addr), 128'(255));

    run_load(8'd10, 100, 50, 1'b1, 1'b0, 4, 1'b0, n);
    check("err_load_count", 128'(n), 128'(10));
    check("err_sticky", 128'(err), 128'(1));

    rand_fields();
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    cycle(1'b0, 8'd3, 1'b1, 1'b0);
    cycle(1'b0, 8'd3, 1'b0, 1'b0);
    do_reset();
    check("rst_midload_en", 128'(bus.mem_wr_en), 128'(0));
    check("rst_midload_err", 128'(err), 128'(0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
